// File: rtl/bp_me_l2_bank_dispatch.sv
// Steers hashed L2 requests to flat bank ports with per-bank credits and in-order response return.
// Optional BP_ME_L2_DISPATCH_PERF_EN adds a saturating head-stall cycle counter (stall_cnt_o).
module bp_me_l2_bank_dispatch #(
  parameter int unsigned slices_p          = 2,
  parameter int unsigned banks_per_slice_p = 2,
  parameter int unsigned daddr_width_p     = 32,
  parameter int unsigned data_width_p      = 64,
  parameter int unsigned req_els_p         = 4,
  parameter int unsigned order_els_p       = 8,
  parameter int unsigned credits_p         = 2,
  localparam int unsigned num_banks_lp = slices_p * banks_per_slice_p,
  localparam int unsigned slice_w_lp   = (slices_p > 1) ? $clog2(slices_p) : 1,
  localparam int unsigned bank_w_lp    = (banks_per_slice_p > 1) ? $clog2(banks_per_slice_p) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   req_v_i,
  output logic                                   req_ready_o,
  input  logic                                   req_w_i,
  input  logic [daddr_width_p-1:0]               req_daddr_i,
  input  logic [slice_w_lp-1:0]                  req_slice_i,
  input  logic [bank_w_lp-1:0]                   req_bank_i,
  input  logic [data_width_p-1:0]                req_data_i,
  output logic [num_banks_lp-1:0]                bank_v_o,
  input  logic [num_banks_lp-1:0]                bank_ready_i,
  output logic                                   bank_w_o,
  output logic [daddr_width_p-1:0]               bank_daddr_o,
  output logic [data_width_p-1:0]                bank_data_o,
  input  logic [num_banks_lp-1:0]                bank_rsp_v_i,
  output logic [num_banks_lp-1:0]                bank_rsp_yumi_o,
  input  logic [num_banks_lp*data_width_p-1:0]   bank_rsp_data_i,
  output logic                                   rsp_v_o,
  output logic [data_width_p-1:0]                rsp_data_o,
  input  logic                                   rsp_yumi_i
`ifdef BP_ME_L2_DISPATCH_PERF_EN
  ,
  output logic [31:0]                            stall_cnt_o
`endif
);

  localparam int unsigned id_w_lp      = (num_banks_lp > 1) ? $clog2(num_banks_lp) : 1;
  localparam int unsigned bank_sh_lp   = (banks_per_slice_p > 1) ? $clog2(banks_per_slice_p) : 0;
  localparam int unsigned cred_w_lp    = $clog2(credits_p + 1);
  localparam int unsigned req_ptr_w_lp = $clog2(req_els_p);
  localparam int unsigned req_cnt_w_lp = $clog2(req_els_p + 1);
  localparam int unsigned ord_ptr_w_lp = $clog2(order_els_p);
  localparam int unsigned ord_cnt_w_lp = $clog2(order_els_p + 1);

  // Reset asserts asynchronously but releases two clocks after reset_n_i rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rst_sync_q <= '0;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [id_w_lp-1:0] req_id;
  always_comb begin
    int unsigned id_int;
    id_int = 0;
    if (slices_p > 1)          id_int = 32'(req_slice_i) << bank_sh_lp;
    if (banks_per_slice_p > 1) id_int = id_int | 32'(req_bank_i);
    req_id = id_w_lp'(id_int);
  end

  logic                      req_w_mem_q     [req_els_p];
  logic [daddr_width_p-1:0]  req_daddr_mem_q [req_els_p];
  logic [data_width_p-1:0]   req_data_mem_q  [req_els_p];
  logic [id_w_lp-1:0]        req_id_mem_q    [req_els_p];
  logic [req_ptr_w_lp-1:0]   req_wr_q, req_wr_d, req_rd_q, req_rd_d;
  logic [req_cnt_w_lp-1:0]   req_cnt_q, req_cnt_d;
  logic                      req_full, req_nempty, req_enq, req_deq;

  logic [id_w_lp-1:0]        ord_mem_q [order_els_p];
  logic [ord_ptr_w_lp-1:0]   ord_wr_q, ord_wr_d, ord_rd_q, ord_rd_d;
  logic [ord_cnt_w_lp-1:0]   ord_cnt_q, ord_cnt_d;
  logic                      ord_full, ord_nempty;

  logic [cred_w_lp-1:0]      credit_q [num_banks_lp];
  logic [cred_w_lp-1:0]      credit_d [num_banks_lp];

  logic [id_w_lp-1:0]        head_id, ord_head;
  logic                      disp_v, disp_fire, rsp_fire;

  assign req_full    = (req_cnt_q == req_cnt_w_lp'(req_els_p));
  assign req_nempty  = (req_cnt_q != '0);
  assign req_ready_o = ~req_full;
  assign req_enq     = req_v_i & ~req_full;
  assign req_deq     = disp_fire;

  assign ord_full    = (ord_cnt_q == ord_cnt_w_lp'(order_els_p));
  assign ord_nempty  = (ord_cnt_q != '0);
  assign ord_head    = ord_mem_q[ord_rd_q];

  assign head_id   = req_id_mem_q[req_rd_q];
  // A full order FIFO blocks dispatch even if a response frees a slot this cycle.
  assign disp_v    = req_nempty & (credit_q[head_id] != '0) & ~ord_full;
  assign disp_fire = disp_v & bank_ready_i[head_id];

  assign rsp_v_o  = ord_nempty & bank_rsp_v_i[ord_head];
  assign rsp_fire = rsp_v_o & rsp_yumi_i;

  always_comb begin
    bank_v_o        = '0;
    bank_rsp_yumi_o = '0;
    if (disp_v)   bank_v_o[head_id]        = 1'b1;
    if (rsp_fire) bank_rsp_yumi_o[ord_head] = 1'b1;
  end

  assign bank_w_o     = req_nempty & req_w_mem_q[req_rd_q];
  assign bank_daddr_o = req_nempty ? req_daddr_mem_q[req_rd_q] : '0;
  assign bank_data_o  = req_nempty ? req_data_mem_q[req_rd_q] : '0;
  assign rsp_data_o   = rsp_v_o ? bank_rsp_data_i[32'(ord_head)*data_width_p +: data_width_p] : '0;

  always_comb begin
    req_wr_d  = req_wr_q;
    req_rd_d  = req_rd_q;
    req_cnt_d = req_cnt_q;
    ord_wr_d  = ord_wr_q;
    ord_rd_d  = ord_rd_q;
    ord_cnt_d = ord_cnt_q;
    if (req_enq) req_wr_d = (req_wr_q == req_ptr_w_lp'(req_els_p - 1)) ? '0 : req_wr_q + 1'b1;
    if (req_deq) req_rd_d = (req_rd_q == req_ptr_w_lp'(req_els_p - 1)) ? '0 : req_rd_q + 1'b1;
    if (req_enq && !req_deq) req_cnt_d = req_cnt_q + 1'b1;
    if (!req_enq && req_deq) req_cnt_d = req_cnt_q - 1'b1;
    if (disp_fire) ord_wr_d = (ord_wr_q == ord_ptr_w_lp'(order_els_p - 1)) ? '0 : ord_wr_q + 1'b1;
    if (rsp_fire)  ord_rd_d = (ord_rd_q == ord_ptr_w_lp'(order_els_p - 1)) ? '0 : ord_rd_q + 1'b1;
    if (disp_fire && !rsp_fire) ord_cnt_d = ord_cnt_q + 1'b1;
    if (!disp_fire && rsp_fire) ord_cnt_d = ord_cnt_q - 1'b1;
  end

  always_comb begin
    for (int b = 0; b < num_banks_lp; b++) begin
      credit_d[b] = credit_q[b];
      if (rsp_fire && (ord_head == id_w_lp'(b)) && !(disp_fire && (head_id == id_w_lp'(b))))
        credit_d[b] = credit_q[b] + 1'b1;
      else if (disp_fire && (head_id == id_w_lp'(b)) && !(rsp_fire && (ord_head == id_w_lp'(b))))
        credit_d[b] = credit_q[b] - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      req_wr_q  <= '0;
      req_rd_q  <= '0;
      req_cnt_q <= '0;
      ord_wr_q  <= '0;
      ord_rd_q  <= '0;
      ord_cnt_q <= '0;
      for (int b = 0; b < num_banks_lp; b++) credit_q[b] <= cred_w_lp'(credits_p);
    end else begin
      req_wr_q  <= req_wr_d;
      req_rd_q  <= req_rd_d;
      req_cnt_q <= req_cnt_d;
      ord_wr_q  <= ord_wr_d;
      ord_rd_q  <= ord_rd_d;
      ord_cnt_q <= ord_cnt_d;
      for (int b = 0; b < num_banks_lp; b++) credit_q[b] <= credit_d[b];
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the counters above.
  always_ff @(posedge clk_i) begin
    if (req_enq) begin
      req_w_mem_q[req_wr_q]     <= req_w_i;
      req_daddr_mem_q[req_wr_q] <= req_daddr_i;
      req_data_mem_q[req_wr_q]  <= req_data_i;
      req_id_mem_q[req_wr_q]    <= req_id;
    end
    if (disp_fire) ord_mem_q[ord_wr_q] <= head_id;
  end

`ifdef BP_ME_L2_DISPATCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (req_nempty && !disp_fire && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end
  assign stall_cnt_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_n) begin
      assert (!(rsp_yumi_i && !rsp_v_o))
        else $error("rsp_yumi_i asserted without rsp_v_o");
      for (int b = 0; b < num_banks_lp; b++)
        assert (!(bank_rsp_v_i[b] && (credit_q[b] == cred_w_lp'(credits_p))))
          else $error("bank %0d responded with no request outstanding", b);
    end
  end
`endif

endmodule

// File: tb/tb_bp_me_l2_bank_dispatch.sv
// Directed bench for bp_me_l2_bank_dispatch: routing, ordering, credits, backpressure, order-full, reset.
// Small order FIFO (3) so order-full and credit limits can be exercised separately.
module tb_bp_me_l2_bank_dispatch;

  localparam int DW = 64;
  localparam int NB = 4;

  logic            clk_i = 1'b0;
  logic            reset_n_i = 1'b0;
  logic            req_v_i = 1'b0;
  logic            req_ready_o;
  logic            req_w_i = 1'b0;
  logic [31:0]     req_daddr_i = '0;
  logic [0:0]      req_slice_i = '0;
  logic [0:0]      req_bank_i = '0;
  logic [DW-1:0]   req_data_i = '0;
  logic [NB-1:0]   bank_v_o;
  logic [NB-1:0]   bank_ready_i = '0;
  logic            bank_w_o;
  logic [31:0]     bank_daddr_o;
  logic [DW-1:0]   bank_data_o;
  logic [NB-1:0]   bank_rsp_v_i = '0;
  logic [NB-1:0]   bank_rsp_yumi_o;
  logic [NB*DW-1:0] bank_rsp_data_i = '0;
  logic            rsp_v_o;
  logic [DW-1:0]   rsp_data_o;
  logic            rsp_yumi_i = 1'b0;
`ifdef BP_ME_L2_DISPATCH_PERF_EN
  logic [31:0]     stall_cnt_o;
  logic [31:0]     s0;
`endif

  int n_chk = 0;
  int n_bad = 0;

  bp_me_l2_bank_dispatch #(
    .slices_p(2), .banks_per_slice_p(2), .daddr_width_p(32), .data_width_p(DW),
    .req_els_p(4), .order_els_p(3), .credits_p(2)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_v_i(req_v_i), .req_ready_o(req_ready_o), .req_w_i(req_w_i),
    .req_daddr_i(req_daddr_i), .req_slice_i(req_slice_i), .req_bank_i(req_bank_i),
    .req_data_i(req_data_i),
    .bank_v_o(bank_v_o), .bank_ready_i(bank_ready_i), .bank_w_o(bank_w_o),
    .bank_daddr_o(bank_daddr_o), .bank_data_o(bank_data_o),
    .bank_rsp_v_i(bank_rsp_v_i), .bank_rsp_yumi_o(bank_rsp_yumi_o),
    .bank_rsp_data_i(bank_rsp_data_i),
    .rsp_v_o(rsp_v_o), .rsp_data_o(rsp_data_o), .rsp_yumi_i(rsp_yumi_i)
`ifdef BP_ME_L2_DISPATCH_PERF_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [1:0] id, input logic w, input logic [31:0] a, input logic [63:0] d);
    req_v_i     = 1'b1;
    req_slice_i = id[1];
    req_bank_i  = id[0];
    req_w_i     = w;
    req_daddr_i = a;
    req_data_i  = d;
    tick();
    req_v_i = 1'b0;
    #1;
  endtask

  task automatic set_rsp(input int b, input logic [63:0] d);
    bank_rsp_data_i[b*DW +: DW] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("rst_ready", req_ready_o, 1);
    chk("rst_bank_v", bank_v_o, 0);
    chk("rst_rsp_v", rsp_v_o, 0);
    chk("rst_rsp_data", rsp_data_o, 0);
    chk("rst_yumi", bank_rsp_yumi_o, 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (3) tick();

    // single read to slice1/bank0 -> bank id 2
    bank_ready_i = 4'b1111;
    push(2'd2, 1'b0, 32'h100, 64'h0);
    chk("t1_bank_v", bank_v_o, 4'b0100);
    chk("t1_daddr", bank_daddr_o, 32'h100);
    chk("t1_w", bank_w_o, 0);
    tick();
    chk("t1_bank_v_clr", bank_v_o, 0);
    bank_rsp_v_i = 4'b0100;
    set_rsp(2, 64'hAB);
    #1;
    chk("t1_rsp_v", rsp_v_o, 1);
    chk("t1_rsp_data", rsp_data_o, 64'hAB);
    chk("t1_no_yumi", bank_rsp_yumi_o, 0);
    rsp_yumi_i = 1'b1;
    #1;
    chk("t1_yumi", bank_rsp_yumi_o, 4'b0100);
    tick();
    rsp_yumi_i = 1'b0;
    bank_rsp_v_i = '0;
    #1;
    chk("t1_rsp_v_clr", rsp_v_o, 0);

    // reorder: bank 0 then bank 3 (write), bank 3 answers first
    push(2'd0, 1'b0, 32'h200, 64'h0);
    push(2'd3, 1'b1, 32'h300, 64'hDEAD);
    chk("t2_bank_v3", bank_v_o, 4'b1000);
    chk("t2_w", bank_w_o, 1);
    chk("t2_wdata", bank_data_o, 64'hDEAD);
    tick();
    bank_rsp_v_i = 4'b1000;
    set_rsp(3, 64'h33);
    #1;
    chk("t2_hold0", rsp_v_o, 0);
    chk("t2_hold_yumi", bank_rsp_yumi_o, 0);
    tick();
    chk("t2_hold1", rsp_v_o, 0);
    bank_rsp_v_i = 4'b1001;
    set_rsp(0, 64'h11);
    #1;
    chk("t2_first", rsp_data_o, 64'h11);
    rsp_yumi_i = 1'b1;
    #1;
    chk("t2_yumi0", bank_rsp_yumi_o, 4'b0001);
    tick();
    bank_rsp_v_i = 4'b1000;
    #1;
    chk("t2_second_v", rsp_v_o, 1);
    chk("t2_second", rsp_data_o, 64'h33);
    chk("t2_yumi3", bank_rsp_yumi_o, 4'b1000);
    tick();
    rsp_yumi_i = 1'b0;
    bank_rsp_v_i = '0;
    #1;
    chk("t2_done", rsp_v_o, 0);

    // credits: three requests to bank 1, credits_p=2
    push(2'd1, 1'b0, 32'h10, 64'h0);
    push(2'd1, 1'b0, 32'h11, 64'h0);
    push(2'd1, 1'b0, 32'h12, 64'h0);
    chk("t3_no_credit", bank_v_o, 0);
    tick();
    chk("t3_no_credit2", bank_v_o, 0);
    bank_rsp_v_i = 4'b0010;
    set_rsp(1, 64'h21);
    rsp_yumi_i = 1'b1;
    #1;
    chk("t3_rsp", rsp_data_o, 64'h21);
    tick();
    rsp_yumi_i = 1'b0;
    bank_rsp_v_i = '0;
    #1;
    chk("t3_redispatch", bank_v_o, 4'b0010);
    chk("t3_daddr", bank_daddr_o, 32'h12);
    tick();
    bank_rsp_v_i = 4'b0010;
    rsp_yumi_i = 1'b1;
    tick();
    tick();
    bank_rsp_v_i = '0;
    rsp_yumi_i = 1'b0;
    #1;
    chk("t3_drained", rsp_v_o, 0);

    // backpressure: banks stalled, push req_els_p+1
    bank_ready_i = '0;
    req_v_i = 1'b1;
    req_slice_i = 1'b0;
    req_bank_i = 1'b0;
    req_w_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_daddr_i = 32'h400 + 32'(i);
      #1;
      chk("t4_ready", req_ready_o, 1);
      tick();
    end
    req_daddr_i = 32'h4FF;
    #1;
    chk("t4_full", req_ready_o, 0);
    chk("t4_bank_v", bank_v_o, 4'b0001);
`ifdef BP_ME_L2_DISPATCH_PERF_EN
    s0 = stall_cnt_o;
`endif
    tick();
    chk("t4_hold", req_ready_o, 0);
`ifdef BP_ME_L2_DISPATCH_PERF_EN
    chk("t4_stall1", stall_cnt_o, s0 + 1);
`endif
    tick();
`ifdef BP_ME_L2_DISPATCH_PERF_EN
    chk("t4_stall2", stall_cnt_o, s0 + 2);
`endif
    bank_ready_i = 4'b0001;
    #1;
    chk("t4_no_bypass", req_ready_o, 0);
    tick();
    req_v_i = 1'b0;
    bank_ready_i = '0;
    #1;
    chk("t4_after_deq", req_ready_o, 1);
    chk("t4_head", bank_daddr_o, 32'h401);
`ifdef BP_ME_L2_DISPATCH_PERF_EN
    chk("t4_stall_fire", stall_cnt_o, s0 + 2);
`endif

    // async reset mid-traffic, between edges
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("t5_ready", req_ready_o, 1);
    chk("t5_bank_v", bank_v_o, 0);
    chk("t5_rsp_v", rsp_v_o, 0);
    chk("t5_rsp_data", rsp_data_o, 0);
`ifdef BP_ME_L2_DISPATCH_PERF_EN
    chk("t5_stall", stall_cnt_o, 0);
`endif
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    repeat (3) tick();

    // credits restored on bank 0, then order FIFO full
    bank_ready_i = 4'b1111;
    push(2'd0, 1'b0, 32'h500, 64'h0);
    push(2'd0, 1'b0, 32'h501, 64'h0);
    chk("t6_credit_restored", bank_v_o, 4'b0001);
    push(2'd1, 1'b0, 32'h502, 64'h0);
    push(2'd3, 1'b0, 32'h503, 64'h0);
    chk("t6_order_full", bank_v_o, 0);
    tick();
    chk("t6_order_full2", bank_v_o, 0);
    bank_rsp_v_i = 4'b0001;
    set_rsp(0, 64'h55);
    rsp_yumi_i = 1'b1;
    #1;
    chk("t6_rsp0", rsp_data_o, 64'h55);
    chk("t6_full_deq_block", bank_v_o, 0);
    tick();
    chk("t6_unblocked", bank_v_o, 4'b1000);
    chk("t6_rsp0b", rsp_data_o, 64'h55);
    tick();
    bank_rsp_v_i = 4'b0010;
    set_rsp(1, 64'h66);
    #1;
    chk("t6_rsp1", rsp_data_o, 64'h66);
    chk("t6_dispatched3", bank_v_o, 0);
    tick();
    bank_rsp_v_i = 4'b1000;
    set_rsp(3, 64'h77);
    #1;
    chk("t6_rsp3", rsp_data_o, 64'h77);
    tick();
    bank_rsp_v_i = '0;
    rsp_yumi_i = 1'b0;
    #1;
    chk("t6_empty", rsp_v_o, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
